// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle carrying a control vector and a data payload
// between two adjacent pipeline stages.
interface pipe_stage_if #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 106
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, flush, saturating bubble counter.
// Define PIPE_SKID_EN for the two-entry skid buffer with a registered d_ready.
module pipe_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 106,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    pipe_stage_if.slave      d,
    pipe_stage_if.master     e,
    output logic [CNT_W-1:0] e_bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t            state;
    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic              ready_int;
    logic              accept;
    logic              retire;

    assign accept  = d.valid & ready_int & ~flush;
    assign retire  = valid_q & e.ready;
    assign d.ready = ready_int;
    assign e.valid = valid_q;
    assign e.ctrl  = ctrl_q;
    assign e.data  = data_q;

`ifdef PIPE_SKID_EN
    logic              ready_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    // Ready comes straight from a flop, so e.ready never reaches d.ready.
    assign ready_int = ready_q;

    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: non-blocking assignments so every branch reads pre-edge register values.
        if (!clrn) begin
            state       <= EMPTY;
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            ready_q     <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            skid_ctrl_q <= '0;
            ready_q     <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= FULL;
                        valid_q <= 1'b1;
                        ctrl_q  <= d.ctrl;
                        data_q  <= d.data;
                    end
                end
                FULL: begin
                    if (accept && e.ready) begin
                        ctrl_q <= d.ctrl;
                        data_q <= d.data;
                    end else if (accept) begin
                        state       <= SKID;
                        skid_ctrl_q <= d.ctrl;
                        skid_data_q <= d.data;
                        ready_q     <= 1'b0;
                    end else if (retire) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                        ctrl_q  <= '0;
                    end
                end
                SKID: begin
                    if (retire) begin
                        state       <= FULL;
                        ctrl_q      <= skid_ctrl_q;
                        data_q      <= skid_data_q;
                        skid_ctrl_q <= '0;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    // Combinational ready: legal only when the downstream ready is registered.
    assign ready_int = e.ready | ~valid_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (flush) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= FULL;
                        valid_q <= 1'b1;
                        ctrl_q  <= d.ctrl;
                        data_q  <= d.data;
                    end
                end
                FULL: begin
                    // In FULL an accept implies the held entry retires on the same edge.
                    if (accept) begin
                        ctrl_q <= d.ctrl;
                        data_q <= d.data;
                    end else if (retire) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                        ctrl_q  <= '0;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            e_bubble_cnt <= '0;
        end else if (!valid_q && (e_bubble_cnt != {CNT_W{1'b1}})) begin
            e_bubble_cnt <= e_bubble_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; covers the skid build when
// PIPE_SKID_EN is defined and the single-register build otherwise.
module tb_pipe_stage_reg;
    localparam int CTRL_W = 9;
    localparam int DATA_W = 106;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             clrn;
    logic             flush;
    logic [CNT_W-1:0] e_bubble_cnt;
    int               n_cmp = 0;
    int               n_mis = 0;

    pipe_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
    pipe_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .flush        (flush),
        .d            (up_if),
        .e            (dn_if),
        .e_bubble_cnt (e_bubble_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [DATA_W-1:0] DA = 106'h3_0123_4567_89AB_CDEF_0123_4567;
    localparam logic [DATA_W-1:0] DB = 106'h2_BEEF_0000_1111_2222_3333_4444;
    localparam logic [DATA_W-1:0] DC = 106'h1_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
    localparam logic [DATA_W-1:0] DZ = 106'h0_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] dd);
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = dd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn        = 1'b1;
        flush       = 1'b0;
        dn_if.ready = 1'b0;
        set_in(1'b0, '0, '0);

        // Reset state
        #1 clrn = 1'b0;
        #1;
        chk("rst_e_valid", dn_if.valid, 1'b0);
        chk("rst_e_ctrl", dn_if.ctrl, '0);
        chk("rst_e_data", dn_if.data, '0);
        chk("rst_cnt", e_bubble_cnt, '0);
        chk("rst_d_ready", up_if.ready, 1'b1);
        #1 clrn = 1'b1;

        // Counter saturation: 20 idle edges with CNT_W=4
        for (int i = 0; i < 20; i++) step();
        chk("cnt_sat", e_bubble_cnt, 4'd15);
        step();
        chk("cnt_sat_hold", e_bubble_cnt, 4'd15);

        // Streaming 1..4 with e_ready=1
        dn_if.ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, CTRL_W'(9'h100 | k), DATA_W'(k));
            step();
            chk($sformatf("stream%0d_valid", k), dn_if.valid, 1'b1);
            chk($sformatf("stream%0d_data", k), dn_if.data, 128'(k));
            chk($sformatf("stream%0d_ctrl", k), dn_if.ctrl, 128'(9'h100 | k));
            chk($sformatf("stream%0d_d_ready", k), up_if.ready, 1'b1);
        end
        set_in(1'b0, '0, '0);
        step();
        chk("stream_end_valid", dn_if.valid, 1'b0);
        chk("stream_end_ctrl", dn_if.ctrl, '0);
        chk("stream_end_data", dn_if.data, 128'd4);

        // Flush discards a coincident handshake in EMPTY
        set_in(1'b1, 9'h1FF, DZ);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, '0, '0);
        chk("flush_empty_valid", dn_if.valid, 1'b0);
        chk("flush_empty_ctrl", dn_if.ctrl, '0);
        chk("flush_empty_data", dn_if.data, 128'd4);

`ifdef PIPE_SKID_EN
        // Back-pressure: A then B absorbed, C refused while in SKID
        dn_if.ready = 1'b0;
        set_in(1'b1, 9'h0A1, DA);
        step();
        chk("bp_a_valid", dn_if.valid, 1'b1);
        chk("bp_a_data", dn_if.data, 128'(DA));
        chk("bp_a_d_ready", up_if.ready, 1'b1);
        set_in(1'b1, 9'h0B2, DB);
        step();
        chk("bp_b_data_holds_a", dn_if.data, 128'(DA));
        chk("bp_b_d_ready", up_if.ready, 1'b0);
        set_in(1'b1, 9'h0C3, DC);
        step();
        chk("bp_c_data_holds_a", dn_if.data, 128'(DA));
        chk("bp_c_ctrl", dn_if.ctrl, 128'(9'h0A1));
        chk("bp_c_d_ready", up_if.ready, 1'b0);
        set_in(1'b0, '0, '0);
        dn_if.ready = 1'b1;
        step();
        chk("drain_b_valid", dn_if.valid, 1'b1);
        chk("drain_b_data", dn_if.data, 128'(DB));
        chk("drain_b_ctrl", dn_if.ctrl, 128'(9'h0B2));
        chk("drain_b_d_ready", up_if.ready, 1'b1);
        step();
        chk("drain_end_valid", dn_if.valid, 1'b0);
        chk("drain_end_ctrl", dn_if.ctrl, '0);
        chk("drain_end_data", dn_if.data, 128'(DB));

        // Flush while in SKID with a live input offer
        dn_if.ready = 1'b0;
        set_in(1'b1, 9'h011, DA);
        step();
        set_in(1'b1, 9'h022, DB);
        step();
        chk("fskid_d_ready_pre", up_if.ready, 1'b0);
        set_in(1'b1, 9'h1FF, DZ);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fskid_valid", dn_if.valid, 1'b0);
        chk("fskid_ctrl", dn_if.ctrl, '0);
        chk("fskid_d_ready", up_if.ready, 1'b1);
        chk("fskid_data_kept", dn_if.data, 128'(DA));
        set_in(1'b0, '0, '0);
        dn_if.ready = 1'b1;
        step();
        chk("fskid_after_valid", dn_if.valid, 1'b0);
        chk("fskid_after_ctrl", dn_if.ctrl, '0);

        // Get back to SKID for the asynchronous reset test
        dn_if.ready = 1'b0;
        set_in(1'b1, 9'h033, DC);
        step();
        set_in(1'b1, 9'h044, DB);
        step();
        chk("pre_rst_d_ready", up_if.ready, 1'b0);
`else
        // Combinational d_ready in the single-register build
        dn_if.ready = 1'b0;
        set_in(1'b1, 9'h0A1, DA);
        #1;
        chk("nos_empty_d_ready", up_if.ready, 1'b1);
        step();
        chk("nos_a_valid", dn_if.valid, 1'b1);
        chk("nos_a_data", dn_if.data, 128'(DA));
        chk("nos_full_d_ready", up_if.ready, 1'b0);
        set_in(1'b1, 9'h0B2, DB);
        step();
        chk("nos_stall_data", dn_if.data, 128'(DA));
        chk("nos_stall_d_ready", up_if.ready, 1'b0);
        dn_if.ready = 1'b1;
        #1;
        chk("nos_comb_d_ready", up_if.ready, 1'b1);
        step();
        chk("nos_b_data", dn_if.data, 128'(DB));
        chk("nos_b_ctrl", dn_if.ctrl, 128'(9'h0B2));
        chk("nos_b_valid", dn_if.valid, 1'b1);
        dn_if.ready = 1'b0;
        set_in(1'b1, 9'h1FF, DZ);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, '0, '0);
        chk("nos_flush_valid", dn_if.valid, 1'b0);
        chk("nos_flush_ctrl", dn_if.ctrl, '0);
        chk("nos_flush_data", dn_if.data, 128'(DB));
        chk("nos_flush_d_ready", up_if.ready, 1'b1);

        // Hold an entry for the asynchronous reset test
        set_in(1'b1, 9'h033, DC);
        step();
        chk("pre_rst_valid", dn_if.valid, 1'b1);
`endif

        // Asynchronous reset between edges
        set_in(1'b0, '0, '0);
        #3 clrn = 1'b0;
        #1;
        chk("arst_e_valid", dn_if.valid, 1'b0);
        chk("arst_e_ctrl", dn_if.ctrl, '0);
        chk("arst_e_data", dn_if.data, '0);
        chk("arst_cnt", e_bubble_cnt, '0);
        chk("arst_d_ready", up_if.ready, 1'b1);
        clrn = 1'b1;

        // Counter counts only cycles where e_valid was low
        for (int i = 0; i < 3; i++) step();
        chk("cnt_three", e_bubble_cnt, 4'd3);
        set_in(1'b1, 9'h055, DA);
        step();
        chk("cnt_four", e_bubble_cnt, 4'd4);
        set_in(1'b0, '0, '0);
        dn_if.ready = 1'b1;
        step();
        chk("cnt_busy_hold", e_bubble_cnt, 4'd4);
        chk("cnt_retired_valid", dn_if.valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
